// File: rtl/mac_rx_frame_buf.sv
// Ethernet MAC receive stage: strips preamble/SFD, checks FCS, length and DA,
// then stores whole frames in a circular byte buffer behind a descriptor queue.
module mac_rx_frame_buf #(
    parameter int BUF_AW      = 11,
    parameter int FQ_AW       = 3,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1522,
    parameter int LEN_W       = 11,
    parameter bit ADDR_FILTER = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             config_ready,
    input  logic             rx_dv,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic [47:0]      local_mac,
    input  logic             promisc,
    input  logic             read_en,
    output logic             frame_received,
    output logic [LEN_W-1:0] frame_len,
    output logic [7:0]       mac_rx_data_out,
    output logic             data_valid,
    output logic             read_complete,
    output logic [15:0]      rx_good_count,
    output logic [15:0]      rx_drop_count
);

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} rx_state_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            default: return mac[7:0];
        endcase
    endfunction

    rx_state_t         state, state_n;
    logic [7:0]        buf_mem [2**BUF_AW];
    logic [BUF_AW-1:0] q_start [2**FQ_AW];
    logic [LEN_W-1:0]  q_len   [2**FQ_AW];

    logic [BUF_AW-1:0] wr_ptr, commit_ptr, rd_base, buf_used;
    logic [LEN_W-1:0]  byte_cnt, rd_off, head_len;
    logic [BUF_AW-1:0] head_start;
    logic [FQ_AW:0]    q_wr, q_rd;
    logic [FQ_AW-1:0]  head_idx;
    logic [31:0]       crc;
    logic              da_uc_ok, da_bc_ok, armed;
    logic              q_empty, q_full, buf_full, len_ok, crc_ok, da_ok;
    logic              start_body, wr_en, commit, drop_inc, rd_pop, rd_last;

    assign q_empty  = (q_wr == q_rd);
    assign q_full   = (q_wr[FQ_AW] != q_rd[FQ_AW]) && (q_wr[FQ_AW-1:0] == q_rd[FQ_AW-1:0]);
    // Space is measured against rd_base, so the frame being read stays reserved.
    assign buf_used = wr_ptr - rd_base;
    assign buf_full = &buf_used;
    assign len_ok   = (int'(byte_cnt) >= MIN_LEN) && (int'(byte_cnt) <= MAX_LEN);
    assign crc_ok   = (crc == CRC_RESIDUE);
    assign da_ok    = !ADDR_FILTER || promisc || da_uc_ok || da_bc_ok;

    always_comb begin
        state_n    = state;
        start_body = 1'b0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv && rx_valid && armed)
                    state_n = (config_ready && rx_data == 8'h55) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                end else if (rx_valid) begin
                    if (rx_data == 8'hD5) begin
                        if (q_full) begin
                            state_n  = DROP;
                            drop_inc = 1'b1;
                        end else begin
                            state_n    = BODY;
                            start_body = 1'b1;
                        end
                    end else if (rx_data != 8'h55) begin
                        state_n = DROP;
                    end
                end
            end
            BODY: begin
                if (!rx_dv) begin
                    state_n = IDLE;
                    if (len_ok && crc_ok && da_ok)
                        commit = 1'b1;
                    else if (!(len_ok && crc_ok))
                        drop_inc = 1'b1;
                end else if (rx_valid) begin
                    if (buf_full) begin
                        state_n  = DROP;
                        drop_inc = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!rx_dv)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Receive stage: FSM, CRC, DA match, write pointer and commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            armed         <= 1'b0;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            byte_cnt      <= '0;
            crc           <= '0;
            da_uc_ok      <= 1'b0;
            da_bc_ok      <= 1'b0;
            q_wr          <= '0;
            rx_good_count <= '0;
            rx_drop_count <= '0;
        end else begin
            state <= state_n;
            // After reset, a frame already in flight is ignored until rx_dv falls.
            if (!rx_dv)
                armed <= 1'b1;
            if (start_body) begin
                crc      <= 32'hFFFFFFFF;
                byte_cnt <= '0;
                wr_ptr   <= commit_ptr;
                da_uc_ok <= 1'b1;
                da_bc_ok <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                byte_cnt <= (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;
                crc      <= crc32_byte(crc, rx_data);
                if (byte_cnt < LEN_W'(6)) begin
                    da_uc_ok <= da_uc_ok && (rx_data == mac_byte(local_mac, byte_cnt[2:0]));
                    da_bc_ok <= da_bc_ok && (rx_data == 8'hFF);
                end
            end
            if (commit) begin
                q_wr          <= q_wr + 1'b1;
                commit_ptr    <= wr_ptr;
                rx_good_count <= sat_inc16(rx_good_count);
            end
            if (drop_inc)
                rx_drop_count <= sat_inc16(rx_drop_count);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            buf_mem[wr_ptr] <= rx_data;
        if (!rst && commit) begin
            q_start[q_wr[FQ_AW-1:0]] <= commit_ptr;
            q_len[q_wr[FQ_AW-1:0]]   <= byte_cnt;
        end
    end

    assign head_idx       = q_rd[FQ_AW-1:0];
    assign head_len       = q_len[head_idx];
    assign head_start     = q_start[head_idx];
    assign frame_received = !q_empty;
    assign frame_len      = q_empty ? '0 : head_len - LEN_W'(4);
    // No pop in the read_complete cycle, so a held read_en never runs into the next frame.
    assign rd_pop         = read_en && !q_empty && !read_complete;
    assign rd_last        = (rd_off == head_len - LEN_W'(5));

    // Read stage: registered byte output, descriptor pop on the last data byte
    always_ff @(posedge clk) begin
        if (rst) begin
            q_rd            <= '0;
            rd_base         <= '0;
            rd_off          <= '0;
            data_valid      <= 1'b0;
            read_complete   <= 1'b0;
            mac_rx_data_out <= '0;
        end else begin
            data_valid    <= rd_pop;
            read_complete <= rd_pop && rd_last;
            if (rd_pop) begin
                mac_rx_data_out <= buf_mem[rd_base + BUF_AW'(rd_off)];
                if (rd_last) begin
                    rd_off  <= '0;
                    rd_base <= head_start + BUF_AW'(head_len);
                    q_rd    <= q_rd + 1'b1;
                end else begin
                    rd_off <= rd_off + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_rx_frame_buf.sv
// Scoreboard bench for mac_rx_frame_buf: frame-level reference model feeds
// expected bytes to a queue that an independent monitor checks on data_valid.
module tb_mac_rx_frame_buf;

    localparam int BUF_AW  = 11;
    localparam int FQ_AW   = 3;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;
    localparam int LEN_W   = 11;

    logic             clk = 1'b0;
    logic             rst, config_ready, rx_dv, rx_valid, promisc, read_en;
    logic [7:0]       rx_data;
    logic [47:0]      local_mac;
    logic             frame_received, data_valid, read_complete;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       mac_rx_data_out;
    logic [15:0]      rx_good_count, rx_drop_count;

    mac_rx_frame_buf #(
        .BUF_AW(BUF_AW), .FQ_AW(FQ_AW), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN),
        .LEN_W(LEN_W), .ADDR_FILTER(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .config_ready(config_ready), .rx_dv(rx_dv),
        .rx_valid(rx_valid), .rx_data(rx_data), .local_mac(local_mac),
        .promisc(promisc), .read_en(read_en), .frame_received(frame_received),
        .frame_len(frame_len), .mac_rx_data_out(mac_rx_data_out),
        .data_valid(data_valid), .read_complete(read_complete),
        .rx_good_count(rx_good_count), .rx_drop_count(rx_drop_count)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    int         exp_len[$];
    int         m_qlen[$];
    int         m_good = 0;
    int         m_drop = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_good"}, rx_good_count, m_good);
        chk({tag, "_drop"}, rx_drop_count, m_drop);
        chk({tag, "_frame_received"}, frame_received, (m_qlen.size() != 0) ? 1 : 0);
    endtask

    task automatic emit(input logic [7:0] b);
        while ($urandom_range(7) == 0) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
    endtask

    // Builds a frame of len bytes (DA..FCS), predicts its fate, then drives it.
    task automatic send_frame(input logic [47:0] da, input int len, input bit bad_fcs,
                              input bit inc_payload);
        logic [7:0]  f[$];
        logic [31:0] c;
        int          used;
        bit          da_ok;
        for (int i = 0; i < 6; i++) f.push_back(da[47-8*i -: 8]);
        for (int i = 6; i < len - 4; i++)
            f.push_back(inc_payload ? 8'(i - 5) : 8'($urandom));
        c = 32'hFFFFFFFF;
        foreach (f[i]) begin
            c = c ^ {24'h0, f[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        if (bad_fcs) f[len-1] = f[len-1] ^ 8'hFF;

        if (config_ready) begin
            used = 0;
            foreach (m_qlen[i]) used += m_qlen[i];
            da_ok = promisc || (da == local_mac) || (da == 48'hFFFFFFFFFFFF);
            if (m_qlen.size() == 2**FQ_AW)               m_drop++;
            else if (used + len > 2**BUF_AW - 1)         m_drop++;
            else if (len < MIN_LEN || len > MAX_LEN || bad_fcs) m_drop++;
            else if (da_ok) begin
                m_good++;
                m_qlen.push_back(len);
                exp_len.push_back(len - 4);
                for (int i = 0; i < len - 4; i++) begin
                    exp_data.push_back(f[i]);
                    exp_last.push_back(i == len - 5);
                end
            end
        end

        rx_dv = 1'b1;
        repeat (7) emit(8'h55);
        emit(8'hD5);
        foreach (f[i]) emit(f[i]);
        rx_valid = 1'b0;
        rx_dv    = 1'b0;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic read_frames(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            int e;
            t = 0;
            while (!frame_received && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!frame_received) begin
                n_tests++;
                n_fail++;
                $display("FAIL frame_wait: frame_received stayed 0, expected a stored frame");
                return;
            end
            e = (exp_len.size() != 0) ? exp_len.pop_front() : -1;
            chk("frame_len", frame_len, e);
            t = 0;
            while (!read_complete && t < 5000) begin
                read_en = ($urandom_range(3) != 0);
                @(negedge clk);
                t++;
            end
            read_en = 1'b0;
            if (!read_complete) begin
                n_tests++;
                n_fail++;
                $display("FAIL read_timeout: read_complete not seen within 5000 cycles");
            end
            if (m_qlen.size() != 0) void'(m_qlen.pop_front());
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_byte", mac_rx_data_out, -1);
                end else begin
                    chk("rd_byte", mac_rx_data_out, exp_data.pop_front());
                    chk("rd_last", read_complete, exp_last.pop_front());
                end
            end else if (read_complete) begin
                chk("read_complete_without_data", read_complete, 0);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [47:0] da;
        rst = 1'b1; config_ready = 1'b1; rx_dv = 1'b0; rx_valid = 1'b0; rx_data = '0;
        local_mac = 48'h112233445566; promisc = 1'b0; read_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_frame_received", frame_received, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_read_complete", read_complete, 0);
        chk("rst_data_out", mac_rx_data_out, 0);
        chk("rst_good", rx_good_count, 0);
        chk("rst_drop", rx_drop_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Good unicast frame with incrementing payload
        send_frame(local_mac, 64, 1'b0, 1'b1);
        check_state("t1");
        chk("t1_good_is_1", rx_good_count, 1);
        chk("t1_frame_len_60", frame_len, 60);
        read_frames(1);
        check_state("t1_read");

        // Corrupted FCS
        send_frame(local_mac, 64, 1'b1, 1'b1);
        chk("t2_drop_is_1", rx_drop_count, 1);
        check_state("t2");

        // DA filtering, promiscuous mode and broadcast
        send_frame(48'h0A0B0C0D0E0F, 64, 1'b0, 1'b0);
        check_state("t3_filtered");
        promisc = 1'b1;
        send_frame(48'h0A0B0C0D0E0F, 64, 1'b0, 1'b0);
        promisc = 1'b0;
        send_frame(48'hFFFFFFFFFFFF, 64, 1'b0, 1'b0);
        check_state("t3_accepted");
        read_frames(2);
        check_state("t3_read");

        // Receive disabled
        config_ready = 1'b0;
        send_frame(local_mac, 64, 1'b0, 1'b0);
        config_ready = 1'b1;
        check_state("cfg_off");

        // Descriptor queue fills; the ninth frame is dropped
        for (int i = 0; i < 9; i++) send_frame(local_mac, 64 + 8 * i, 1'b0, 1'b0);
        check_state("t4_full");
        read_frames(1);
        send_frame(local_mac, 100, 1'b0, 1'b0);
        check_state("t4_refill");
        read_frames(m_qlen.size());
        check_state("t4_drain");

        read_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_read_data_valid", data_valid, 0);
        end
        read_en = 1'b0;
        @(negedge clk);

        // Too short and too long
        d0 = rx_drop_count;
        send_frame(local_mac, 40, 1'b0, 1'b0);
        send_frame(local_mac, 1600, 1'b0, 1'b0);
        chk("t5_drop_delta", rx_drop_count - d0, 2);
        check_state("t5");

        // Buffer overflow on the sixth 400-byte frame
        d0 = rx_drop_count;
        for (int i = 0; i < 6; i++) send_frame(local_mac, 400, 1'b0, 1'b0);
        chk("ovf_drop_delta", rx_drop_count - d0, 1);
        check_state("ovf");
        read_frames(m_qlen.size());

        // Length boundaries
        send_frame(local_mac, 63, 1'b0, 1'b0);
        send_frame(local_mac, 64, 1'b0, 1'b0);
        send_frame(local_mac, 1523, 1'b0, 1'b0);
        send_frame(local_mac, 1522, 1'b0, 1'b0);
        check_state("bound");
        read_frames(m_qlen.size());
        check_state("bound_read");

        // Reset in the middle of a frame body
        rx_dv = 1'b1;
        repeat (7) emit(8'h55);
        emit(8'hD5);
        repeat (20) emit(8'($urandom));
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h3C;
        @(negedge clk);
        rst = 1'b0;
        m_good = 0; m_drop = 0; m_qlen.delete();
        emit(8'h55); emit(8'h55); emit(8'h55); emit(8'hD5);
        repeat (12) emit(8'($urandom));
        emit(8'h55); emit(8'hD5);
        rx_valid = 1'b0; rx_dv = 1'b0;
        @(negedge clk);
        check_state("t6_after_rst");
        send_frame(local_mac, 70, 1'b0, 1'b1);
        chk("t6_good_is_1", rx_good_count, 1);
        chk("t6_drop_is_0", rx_drop_count, 0);
        read_frames(1);

        // Randomised batches
        for (int b = 0; b < 5; b++) begin
            int nf;
            nf = $urandom_range(1, 10);
            for (int k = 0; k < nf; k++) begin
                int r;
                int len;
                r = $urandom_range(0, 9);
                case (r)
                    0: len = 63;
                    1: len = 64;
                    2: len = 1522;
                    3: len = 1523;
                    4: len = 40;
                    default: len = $urandom_range(64, 400);
                endcase
                case ($urandom_range(0, 2))
                    0: da = local_mac;
                    1: da = {8'h0A, 40'($urandom)};
                    default: da = 48'hFFFFFFFFFFFF;
                endcase
                promisc = ($urandom_range(0, 3) == 0);
                send_frame(da, len, ($urandom_range(0, 4) == 0), 1'b0);
            end
            promisc = 1'b0;
            check_state("rand_batch");
            read_frames(m_qlen.size());
            check_state("rand_drain");
        end

        repeat (3) @(negedge clk);
        chk("exp_data_left", exp_data.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
